mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameters SHALL be: width, 8, data word width; length, 8, address width; TIMEOUT, 15, maximum RD-state cycles before abort (legal range 1..255).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 clr  input  1  reset, asynchronous, active-high.
REQ-004 reqValid  input  1  processor requests a memory access.
REQ-005 reqWrite  input  1  1 = write, 0 = read.
REQ-006 reqIndirect  input  1  read uses indirect addressing.
REQ-007 reqAddr  input  length  access address.
REQ-008 reqData  input  width  write data.
REQ-009 reqReady  output  1  controller can accept a request.
REQ-010 respValid  output  1  access complete; respData and respError valid.
REQ-011 respReady  input  1  processor consumes the response.
REQ-012 respData  output  width  read result; 0 for writes and timeouts.
REQ-013 respError  output  1  read timed out.
REQ-014 ramWriteEnable, ramReadEnable, ramIndirect  output  1 each  RAM control strobes.
REQ-015 ramAddr  output  length; ramWriteData  output  width; RAM address and write data.
REQ-016 ramDataReady  input  1; ramReadData  input  width; RAM read handshake and data.

Function
REQ-017 The controller SHALL implement states IDLE, WR, RD, CAP, RESP.
REQ-018 reqReady SHALL equal (state == IDLE); requests in any other state SHALL be ignored.
REQ-019 IDLE: on posedge with reqValid=1, the controller SHALL latch reqWrite, reqIndirect, reqAddr and reqData, then go to WR if reqWrite=1, else to RD.
REQ-020 ramAddr, ramWriteData and ramIndirect SHALL be driven from the latched values in WR, RD and CAP, and SHALL stay stable for the whole access.
REQ-021 WR: ramWriteEnable SHALL be 1 for exactly one cycle; at the next posedge the controller SHALL go to RESP with respData=0 and respError=0.
REQ-022 RD: ramReadEnable SHALL be 1, and the wait counter SHALL increment each cycle starting from 0.
REQ-023 RD, posedge with ramDataReady=1: the controller SHALL go to CAP.
REQ-024 RD, posedge with ramDataReady=0 and counter = TIMEOUT-1: the controller SHALL go to RESP with respError=1 and respData=0.
REQ-025 RD, simultaneous ramDataReady=1 and timeout: ready SHALL win (go to CAP, no error).
REQ-026 CAP: all RAM strobes SHALL be 0; at the next posedge the controller SHALL latch respData=ramReadData and respError=0, then go to RESP.
REQ-027 RESP: respValid SHALL be 1 and respData/respError SHALL be held; at a posedge with respReady=1 the controller SHALL go to IDLE.
REQ-028 respValid SHALL be 0 outside RESP; respReady outside RESP SHALL be ignored.
REQ-029 No bypass: a request present while in RESP SHALL be accepted no earlier than the first IDLE cycle.
REQ-030 Outside WR and RD, ramWriteEnable and ramReadEnable SHALL be 0; ramAddr, ramWriteData and ramIndirect SHALL be 0 in IDLE and RESP.
REQ-031 Best-case latency SHALL be: write, acceptance edge to respValid = 2 cycles; read, acceptance edge to respValid = 3 cycles when ramDataReady is sampled at the first RD edge.

Reset
REQ-032 When clr=1, immediately and asynchronously: state = IDLE, counter = 0, latched registers = 0, all outputs 0 except reqReady = 1 after release.
REQ-033 Reset asserted mid-access (WR/RD/CAP/RESP) SHALL drop all RAM strobes at once, discard the access, and produce no response.

Verification
REQ-034 Write: reqValid, reqWrite=1, addr 0x05, data 0xA5 -> ramWriteEnable high exactly 1 cycle with ramAddr=0x05 and ramWriteData=0xA5; respValid next cycle; respData=0, respError=0.
REQ-035 Direct read: addr 0x03, RAM asserts ramDataReady on the first RD cycle with data 0x3C -> respValid 3 cycles after acceptance; respData=0x3C; ramIndirect=0.
REQ-036 Indirect read: reqIndirect=1, addr 0x10 -> ramIndirect=1 throughout RD; the returned 0x77 is delivered on respData.
REQ-037 Timeout: TIMEOUT=4, ramDataReady held 0 -> ramReadEnable high exactly 4 cycles, then respValid=1, respError=1, respData=0.
REQ-038 Backpressure/overlap: respReady held 0 for 5 cycles while reqValid=1 -> respValid and respData held, reqReady=0, no RAM strobe; on respReady=1, next request accepted in the following IDLE cycle.
REQ-039 Reset mid-read: clr pulsed during RD -> ramReadEnable falls without waiting for clk, respValid never asserts, reqReady=1 after release.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Single-outstanding memory access controller between a processor request
// port and a RAM with a read-ready handshake. Each request is a write
// (one-cycle RAM write strobe) or a read (strobe held until the RAM reports
// ready or the wait budget runs out). The result is presented on the
// response port until the processor consumes it.
//
// Handshake semantics (both ports): a transfer happens on a posedge where
// the producer's valid and the consumer's ready are both 1. reqReady is 1
// only in IDLE, so a request is taken exactly on an IDLE posedge with
// reqValid=1. respValid is 1 only in RESP, and the response is consumed on
// a RESP posedge with respReady=1. Requests and respReady seen in any other
// state have no effect, and the response is never bypassed into a new
// request in the same cycle.
//
// Ports
//   clk, clr            clock; asynchronous active-high reset
//   reqValid/reqReady   request handshake
//   reqWrite            1 = write, 0 = read
//   reqIndirect         read uses indirect addressing
//   reqAddr, reqData    access address and write data
//   respValid/respReady response handshake
//   respData, respError read result (0 for writes/timeouts), timeout flag
//   ramWriteEnable, ramReadEnable, ramIndirect, ramAddr, ramWriteData
//                       RAM control strobes, address and write data
//   ramDataReady, ramReadData  RAM read completion and data
//   dbg_state           current FSM state (IDLE=0, WR=1, RD=2, CAP=3, RESP=4)

module mem_access_ctrl #(
  parameter int width   = 8,
  parameter int length  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              reqValid,
  input  logic              reqWrite,
  input  logic              reqIndirect,
  input  logic [length-1:0] reqAddr,
  input  logic [width-1:0]  reqData,
  output logic              reqReady,
  output logic              respValid,
  input  logic              respReady,
  output logic [width-1:0]  respData,
  output logic              respError,
  output logic              ramWriteEnable,
  output logic              ramReadEnable,
  output logic              ramIndirect,
  output logic [length-1:0] ramAddr,
  output logic [width-1:0]  ramWriteData,
  input  logic              ramDataReady,
  input  logic [width-1:0]  ramReadData,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    CAP  = 3'd3,
    RESP = 3'd4
  } state_t;

  // Last RD cycle index before the access is abandoned.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t             state, state_n;
  logic [7:0]         cnt, cnt_n;
  logic               lat_ind, lat_ind_n;
  logic [length-1:0]  lat_addr, lat_addr_n;
  logic [width-1:0]   lat_data, lat_data_n;
  logic [width-1:0]   rsp_data, rsp_data_n;
  logic               rsp_err, rsp_err_n;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      cnt      <= '0;
      lat_ind  <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      lat_ind  <= lat_ind_n;
      lat_addr <= lat_addr_n;
      lat_data <= lat_data_n;
      rsp_data <= rsp_data_n;
      rsp_err  <= rsp_err_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    lat_ind_n  = lat_ind;
    lat_addr_n = lat_addr;
    lat_data_n = lat_data;
    rsp_data_n = rsp_data;
    rsp_err_n  = rsp_err;

    unique case (state)
      IDLE: begin
        if (reqValid) begin
          lat_ind_n  = reqIndirect;
          lat_addr_n = reqAddr;
          lat_data_n = reqData;
          cnt_n      = '0;
          state_n    = reqWrite ? WR : RD;
        end
      end
      WR: begin
        rsp_data_n = '0;
        rsp_err_n  = 1'b0;
        state_n    = RESP;
      end
      RD: begin
        cnt_n = cnt + 8'd1;
        // Data ready takes priority over an expiring wait budget.
        if (ramDataReady) begin
          state_n = CAP;
        end else if (cnt == LAST_WAIT) begin
          rsp_data_n = '0;
          rsp_err_n  = 1'b1;
          state_n    = RESP;
        end
      end
      CAP: begin
        rsp_data_n = ramReadData;
        rsp_err_n  = 1'b0;
        state_n    = RESP;
      end
      RESP: begin
        if (respReady) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs decode the registered state only, so an asserted clr (which
  // forces state to IDLE asynchronously) drops every strobe at once.
  logic access;
  assign access = (state == WR) || (state == RD) || (state == CAP);

  assign reqReady       = (state == IDLE) && !clr;
  assign respValid      = (state == RESP);
  assign respData       = (state == RESP) ? rsp_data : '0;
  assign respError      = (state == RESP) && rsp_err;
  assign ramWriteEnable = (state == WR);
  assign ramReadEnable  = (state == RD);
  assign ramIndirect    = access && lat_ind;
  assign ramAddr        = access ? lat_addr : '0;
  assign ramWriteData   = access ? lat_data : '0;
  assign dbg_state      = state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl. Each driver task describes one whole access
// (kind, address, RAM ready delay, response hold) and derives the output
// trace the access must produce cycle by cycle, pushing one expected output
// vector per cycle into exp_q. A single compare process pops and checks a
// vector on every falling edge. Directed accesses pin the model with
// literal expectations (strobe counts, latency, returned data).
module tb_mem_access_ctrl;
  localparam int W   = 8;
  localparam int L   = 8;
  localparam int TMO = 4;
  localparam int VW  = 30;

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic         reqValid = 1'b0, reqWrite = 1'b0, reqIndirect = 1'b0;
  logic [L-1:0] reqAddr = '0;
  logic [W-1:0] reqData = '0;
  logic         reqReady, respValid;
  logic         respReady = 1'b0;
  logic [W-1:0] respData;
  logic         respError;
  logic         ramWriteEnable, ramReadEnable, ramIndirect;
  logic [L-1:0] ramAddr;
  logic [W-1:0] ramWriteData;
  logic         ramDataReady = 1'b0;
  logic [W-1:0] ramReadData = '0;
  logic [2:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  logic [VW-1:0] exp_q[$];

  mem_access_ctrl #(.width(W), .length(L), .TIMEOUT(TMO)) dut (
    .clk(clk), .clr(clr), .reqValid(reqValid), .reqWrite(reqWrite),
    .reqIndirect(reqIndirect), .reqAddr(reqAddr), .reqData(reqData),
    .reqReady(reqReady), .respValid(respValid), .respReady(respReady),
    .respData(respData), .respError(respError),
    .ramWriteEnable(ramWriteEnable), .ramReadEnable(ramReadEnable),
    .ramIndirect(ramIndirect), .ramAddr(ramAddr), .ramWriteData(ramWriteData),
    .ramDataReady(ramDataReady), .ramReadData(ramReadData),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] vec(input logic rdy, input logic val,
      input logic [7:0] rd, input logic err, input logic we, input logic re,
      input logic ind, input logic [7:0] a, input logic [7:0] wd);
    return {rdy, val, rd, err, we, re, ind, a, wd};
  endfunction

  localparam logic [VW-1:0] IDLE_V = {1'b1, 29'd0};

  // ---------------- scoreboard compare + monitors ----------------
  int   we_cnt = 0, re_cnt = 0;
  bit   resp_seen = 1'b0;
  int   req_cyc = 0, resp_cyc = 0;
  logic [W-1:0] last_rdata = '0;
  logic last_rerr = 1'b0;

  always @(negedge clk) begin
    logic [VW-1:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("cycle_outputs",
          32'(vec(reqReady, respValid, respData, respError, ramWriteEnable,
                  ramReadEnable, ramIndirect, ramAddr, ramWriteData)),
          32'(e));
    end
    if (!clr) begin
      if (ramWriteEnable) we_cnt++;
      if (ramReadEnable) re_cnt++;
      if (respValid) begin
        last_rdata = respData;
        last_rerr  = respError;
        if (!resp_seen) begin
          resp_seen = 1'b1;
          resp_cyc  = cyc;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Request-side garbage while the controller is busy: it must be ignored.
  task automatic busy_inputs();
    reqValid     = 1'b1;
    reqWrite     = 1'($urandom_range(0, 1));
    reqIndirect  = 1'($urandom_range(0, 1));
    reqAddr      = 8'($urandom_range(0, 255));
    reqData      = 8'($urandom_range(0, 255));
    respReady    = 1'($urandom_range(0, 1));
    ramDataReady = 1'($urandom_range(0, 1));
    ramReadData  = 8'($urandom_range(0, 255));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      reqValid     = 1'b0;
      reqWrite     = 1'($urandom_range(0, 1));
      reqAddr      = 8'($urandom_range(0, 255));
      respReady    = 1'($urandom_range(0, 1));
      ramDataReady = 1'($urandom_range(0, 1));
      exp_q.push_back(IDLE_V);
      next_cycle();
    end
  endtask

  // Present a request in an IDLE cycle; it is taken at the next edge.
  task automatic present(input logic wr, input logic ind, input logic [7:0] a,
                         input logic [7:0] d);
    reqValid = 1'b1; reqWrite = wr; reqIndirect = ind; reqAddr = a; reqData = d;
    respReady    = 1'($urandom_range(0, 1));
    ramDataReady = 1'($urandom_range(0, 1));
    exp_q.push_back(IDLE_V);
    req_cyc   = cyc;
    resp_seen = 1'b0;
    we_cnt    = 0;
    re_cnt    = 0;
    next_cycle();
  endtask

  // Response is held for 'hold' stalled cycles, then consumed.
  task automatic do_resp(input logic [7:0] rd, input logic err, input int hold);
    for (int i = 0; i <= hold; i++) begin
      busy_inputs();
      respReady = (i == hold);
      exp_q.push_back(vec(1'b0, 1'b1, rd, err, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00));
      next_cycle();
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d,
                          input logic ind, input int hold);
    present(1'b1, ind, a, d);
    busy_inputs();
    exp_q.push_back(vec(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, ind, a, d));
    next_cycle();
    do_resp(8'h00, 1'b0, hold);
  endtask

  // RAM reports ready in RD cycle 'dly' (0 = first RD cycle); if that is not
  // within the TMO-cycle budget the read times out.
  task automatic do_read(input logic [7:0] a, input logic ind, input logic [7:0] d,
                         input int dly, input int hold);
    logic [7:0] wd;
    bit timed_out;
    wd = 8'($urandom_range(0, 255));
    present(1'b0, ind, a, wd);
    timed_out = 1'b1;
    for (int k = 0; k < TMO; k++) begin
      busy_inputs();
      ramDataReady = (k == dly);
      if (k == dly) ramReadData = d;
      exp_q.push_back(vec(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, ind, a, wd));
      next_cycle();
      if (k == dly) begin
        timed_out = 1'b0;
        break;
      end
    end
    if (!timed_out) begin
      busy_inputs();
      ramReadData = d;
      exp_q.push_back(vec(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, ind, a, wd));
      next_cycle();
      do_resp(d, 1'b0, hold);
    end else begin
      do_resp(8'h00, 1'b1, hold);
    end
  endtask

  // Read that is cut short by clr in its second RD cycle.
  task automatic reset_mid_read();
    present(1'b0, 1'b1, 8'h42, 8'h11);
    busy_inputs();
    ramDataReady = 1'b0;
    exp_q.push_back(vec(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h42, 8'h11));
    next_cycle();
    busy_inputs();
    ramDataReady = 1'b0;
    #2;
    chk("rd_before_clr", 32'(ramReadEnable), 32'd1);
    clr = 1'b1;
    reqValid = 1'b0;
    #1;
    chk("clr_rd_drop", 32'(ramReadEnable), 32'd0);
    chk("clr_ind_drop", 32'(ramIndirect), 32'd0);
    chk("clr_addr_zero", 32'(ramAddr), 32'd0);
    chk("clr_no_resp", 32'(respValid), 32'd0);
    chk("clr_ready_low", 32'(reqReady), 32'd0);
    next_cycle();
    clr = 1'b0;
    #1;
    chk("ready_after_clr", 32'(reqReady), 32'd1);
    idle_cycles(3);
    chk("no_resp_after_clr", 32'(resp_seen), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #12;
    chk("rst_ready", 32'(reqReady), 32'd0);
    chk("rst_valid", 32'(respValid), 32'd0);
    chk("rst_strobes", 32'({ramWriteEnable, ramReadEnable, ramIndirect}), 32'd0);
    chk("rst_addr", 32'(ramAddr), 32'd0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    #1;
    chk("ready_after_rst", 32'(reqReady), 32'd1);
    @(posedge clk);
    #1;
    idle_cycles(2);

    // Write 0xA5 to 0x05.
    do_write(8'h05, 8'hA5, 1'b0, 0);
    chk("wr_we_cycles", 32'(we_cnt), 32'd1);
    chk("wr_latency", 32'(resp_cyc - req_cyc), 32'd2);
    chk("wr_resp_data", 32'(last_rdata), 32'h00);
    chk("wr_resp_err", 32'(last_rerr), 32'd0);
    idle_cycles(1);

    // Direct read, ready in the first RD cycle.
    do_read(8'h03, 1'b0, 8'h3C, 0, 0);
    chk("rd_latency", 32'(resp_cyc - req_cyc), 32'd3);
    chk("rd_data", 32'(last_rdata), 32'h3C);
    chk("rd_err", 32'(last_rerr), 32'd0);
    idle_cycles(1);

    // Indirect read with a short wait.
    do_read(8'h10, 1'b1, 8'h77, 2, 1);
    chk("ind_data", 32'(last_rdata), 32'h77);
    chk("ind_re_cycles", 32'(re_cnt), 32'd3);

    // Timeout.
    do_read(8'h20, 1'b0, 8'h99, TMO + 2, 0);
    chk("to_re_cycles", 32'(re_cnt), 32'd4);
    chk("to_err", 32'(last_rerr), 32'd1);
    chk("to_data", 32'(last_rdata), 32'h00);

    // Ready on the last budget cycle wins over the timeout.
    do_read(8'h21, 1'b0, 8'h5A, TMO - 1, 0);
    chk("edge_err", 32'(last_rerr), 32'd0);
    chk("edge_data", 32'(last_rdata), 32'h5A);

    // Backpressure with requests pending, then back-to-back next request.
    do_write(8'h33, 8'hC3, 1'b1, 5);
    do_read(8'h44, 1'b0, 8'hE1, 1, 5);
    chk("bp_data", 32'(last_rdata), 32'hE1);

    reset_mid_read();

    // Randomized accesses.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 0)
        do_write(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      else
        do_read(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 255)), $urandom_range(0, TMO + 1),
                $urandom_range(0, 3));
      idle_cycles($urandom_range(0, 2));
    end

    idle_cycles(2);
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
